// File: rtl/next_xhat_precalc.sv
// -----------------------------------------------------------------------------
// next_xhat_precalc
//
// Final-reconstruction stage of the LCPLC block compressor. For every sample
// it joins three AXI-Stream inputs (raw reconstruction, prediction and the
// per-block distortion flag) and picks xhat when the flag is set, otherwise
// xtilde. The picked sample goes out on xhatout one cycle later. The design
// also accumulates the picked samples of each block of 2^BLOCK_SIZE_LOG and
// emits their mean on xhatoutmean, together with the block's last sample.
//
// Optional feature: define XHAT_MEAN_ROUND_EN to round the mean half up. When
// it is undefined the mean is the floor of the sum divided by the block size.
// The ports are the same in both builds.
//
// Ports:
//   clk                clock, all state changes on the rising edge
//   rst                asynchronous reset, active low
//   xhat_*             raw reconstructed sample stream (in)
//   xtilde_*           predicted sample stream (in)
//   d_flag_*           block distortion flag stream (in), one beat per block,
//                      1 = select xhat, 0 = select xtilde
//   xhatout_*          selected sample stream (out), one beat per sample
//   xhatoutmean_*      block mean stream (out), one beat per block
// -----------------------------------------------------------------------------
module next_xhat_precalc #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned BLOCK_SIZE_LOG = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] xhat_data,
    input  logic                  xhat_valid,
    output logic                  xhat_ready,

    input  logic [DATA_WIDTH-1:0] xtilde_data,
    input  logic                  xtilde_valid,
    output logic                  xtilde_ready,

    input  logic                  d_flag_data,
    input  logic                  d_flag_valid,
    output logic                  d_flag_ready,

    output logic [DATA_WIDTH-1:0] xhatout_data,
    output logic                  xhatout_valid,
    input  logic                  xhatout_ready,

    output logic [DATA_WIDTH-1:0] xhatoutmean_data,
    output logic                  xhatoutmean_valid,
    input  logic                  xhatoutmean_ready
);

    // -------------------------------------------------------------------------
    // Widths
    // -------------------------------------------------------------------------
    localparam int unsigned CntWidth = BLOCK_SIZE_LOG;

`ifdef XHAT_MEAN_ROUND_EN
    // One spare bit so that adding the rounding constant cannot wrap.
    localparam int unsigned AccWidth = DATA_WIDTH + BLOCK_SIZE_LOG + 1;
    localparam logic [AccWidth-1:0] RoundHalf = AccWidth'(1) << (BLOCK_SIZE_LOG - 1);
`else
    localparam int unsigned AccWidth = DATA_WIDTH + BLOCK_SIZE_LOG;
`endif

    localparam logic [CntWidth-1:0] CntLast = {CntWidth{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CntWidth-1:0]   cnt_q,        cnt_d;
    logic [AccWidth-1:0]   acc_q,        acc_d;
    logic [DATA_WIDTH-1:0] out_data_q,   out_data_d;
    logic                  out_valid_q,  out_valid_d;
    logic [DATA_WIDTH-1:0] mean_data_q,  mean_data_d;
    logic                  mean_valid_q, mean_valid_d;

    // -------------------------------------------------------------------------
    // Handshake / join
    // -------------------------------------------------------------------------
    logic                  is_last;
    logic                  out_space;
    logic                  mean_space;
    logic                  slot_ok;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_sample;
    logic [AccWidth-1:0]   sel_ext;
    logic [AccWidth-1:0]   block_sum;

    always_comb begin
        is_last    = (cnt_q == CntLast);
        // A register can take a new beat when it is empty or drains this cycle.
        out_space  = ~out_valid_q | xhatout_ready;
        mean_space = ~mean_valid_q | xhatoutmean_ready;
        // Only the block's last sample needs room in the mean register, which
        // leaves a whole block of slack for the mean consumer. Gating with rst
        // keeps every ready low while reset is held.
        slot_ok    = rst & out_space & (~is_last | mean_space);

        // Each ready looks at the other streams' valids but never its own.
        xhat_ready   = slot_ok & xtilde_valid & d_flag_valid;
        xtilde_ready = slot_ok & xhat_valid & d_flag_valid;
        // The flag is held for the whole block and popped with its last sample.
        d_flag_ready = slot_ok & is_last & xhat_valid & xtilde_valid;

        accept = slot_ok & xhat_valid & xtilde_valid & d_flag_valid;
    end

    // -------------------------------------------------------------------------
    // Sample selection and block sum
    // -------------------------------------------------------------------------
    always_comb begin
        sel_sample = d_flag_data ? xhat_data : xtilde_data;
        sel_ext    = AccWidth'(sel_sample);
        block_sum  = acc_q + sel_ext;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        mean_data_d  = mean_data_q;
        mean_valid_d = mean_valid_q;

        // Sample output register: load on accept, otherwise clear when drained.
        if (accept) begin
            out_data_d  = sel_sample;
            out_valid_d = 1'b1;
        end else if (xhatout_ready) begin
            out_valid_d = 1'b0;
        end

        // Mean output register drains independently of the sample register.
        if (mean_valid_q && xhatoutmean_ready) begin
            mean_valid_d = 1'b0;
        end

        if (accept) begin
            // Power-of-two block size: the counter wraps to 0 by itself.
            cnt_d = cnt_q + CntWidth'(1);
            if (is_last) begin
                acc_d        = '0;
`ifdef XHAT_MEAN_ROUND_EN
                mean_data_d  = DATA_WIDTH'((block_sum + RoundHalf) >> BLOCK_SIZE_LOG);
`else
                mean_data_d  = DATA_WIDTH'(block_sum >> BLOCK_SIZE_LOG);
`endif
                mean_valid_d = 1'b1;
            end else begin
                acc_d = block_sum;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            mean_data_q  <= '0;
            mean_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            mean_data_q  <= mean_data_d;
            mean_valid_q <= mean_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        xhatout_data      = out_data_q;
        xhatout_valid     = out_valid_q;
        xhatoutmean_data  = mean_data_q;
        xhatoutmean_valid = mean_valid_q;
    end

endmodule

// File: tb/tb_next_xhat_precalc.sv
// -----------------------------------------------------------------------------
// tb_next_xhat_precalc
//
// Scoreboard bench for next_xhat_precalc (default parameters: 16-bit data,
// 256-sample blocks). Stimulus tasks push input beats into per-stream queues
// and the expected outputs into scoreboard queues; producer processes drive
// the inputs, and a monitor on the falling edge pops and compares whenever an
// output beat is handed over.
// -----------------------------------------------------------------------------
module tb_next_xhat_precalc;

    logic        clk;
    logic        rst;
    logic [15:0] xhat_data;
    logic        xhat_valid;
    logic        xhat_ready;
    logic [15:0] xtilde_data;
    logic        xtilde_valid;
    logic        xtilde_ready;
    logic        d_flag_data;
    logic        d_flag_valid;
    logic        d_flag_ready;
    logic [15:0] xhatout_data;
    logic        xhatout_valid;
    logic        xhatout_ready;
    logic [15:0] xhatoutmean_data;
    logic        xhatoutmean_valid;
    logic        xhatoutmean_ready;

    next_xhat_precalc #(
        .DATA_WIDTH    (16),
        .BLOCK_SIZE_LOG(8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .xhat_data        (xhat_data),
        .xhat_valid       (xhat_valid),
        .xhat_ready       (xhat_ready),
        .xtilde_data      (xtilde_data),
        .xtilde_valid     (xtilde_valid),
        .xtilde_ready     (xtilde_ready),
        .d_flag_data      (d_flag_data),
        .d_flag_valid     (d_flag_valid),
        .d_flag_ready     (d_flag_ready),
        .xhatout_data     (xhatout_data),
        .xhatout_valid    (xhatout_valid),
        .xhatout_ready    (xhatout_ready),
        .xhatoutmean_data (xhatoutmean_data),
        .xhatoutmean_valid(xhatoutmean_valid),
        .xhatoutmean_ready(xhatoutmean_ready)
    );

`ifdef XHAT_MEAN_ROUND_EN
    localparam int RampMean = 128;
`else
    localparam int RampMean = 127;
`endif

    // Stimulus and scoreboard queues.
    logic [15:0] xq[$];
    logic [15:0] tq[$];
    logic        fq[$];
    logic [15:0] exp_out[$];
    logic [15:0] exp_mean[$];

    int  checks    = 0;
    int  errors    = 0;
    int  nsamp     = 0;
    int  dflag_cnt = 0;
    bit  xhat_fire, xtilde_fire, dflag_fire;
    bit  flush     = 0;
    bit  bp_in     = 0;
    bit  bp_out    = 0;
    bit  hold_mean = 0;
    bit  out_hold  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue one block (or a partial one) of stimulus plus its expected outputs.
    // mode 0: constant xhat=a; 1: xhat ramp 0..n-1; 2: xhat=i*37+a, xtilde=i*11+b.
    // hand_mean < 0 means the mean is computed here from the selected samples.
    task automatic push_block(input logic flag, input int mode, input logic [15:0] a,
                              input logic [15:0] b, input int n, input int hand_mean,
                              input bit with_flag);
        logic [31:0] sum;
        logic [15:0] x, t, s, m;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       x = a;
                1:       x = 16'(i);
                default: x = 16'(i * 37) + a;
            endcase
            t = (mode == 2) ? 16'(i * 11) + b : b;
            s = flag ? x : t;
            sum += 32'(s);
            xq.push_back(x);
            tq.push_back(t);
            exp_out.push_back(s);
        end
        if (with_flag) fq.push_back(flag);
        if (n == 256) begin
`ifdef XHAT_MEAN_ROUND_EN
            m = 16'((sum + 32'd128) >> 8);
`else
            m = 16'(sum >> 8);
`endif
            exp_mean.push_back(hand_mean >= 0 ? 16'(hand_mean) : m);
        end
    endtask

    task automatic wait_idle(input string name, input bit need_flag);
        int n;
        n = 0;
        while ((xq.size() != 0 || tq.size() != 0 || exp_out.size() != 0 ||
                exp_mean.size() != 0 || xhat_valid || xtilde_valid ||
                (need_flag && (fq.size() != 0 || d_flag_valid))) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d samples and %0d means still expected",
                     name, exp_out.size(), exp_mean.size());
        end
        repeat (2) @(posedge clk);
    endtask

    // Producers: present the next queued beat once the previous one was taken.
    initial begin
        xhat_valid = 1'b0;
        xhat_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (flush) begin
                xhat_valid = 1'b0;
                xq.delete();
            end else begin
                if (xhat_fire) xhat_valid = 1'b0;
                if (!xhat_valid && xq.size() != 0 && (!bp_in || $urandom_range(0, 3) != 0)) begin
                    xhat_data  = xq.pop_front();
                    xhat_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        xtilde_valid = 1'b0;
        xtilde_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (flush) begin
                xtilde_valid = 1'b0;
                tq.delete();
            end else begin
                if (xtilde_fire) xtilde_valid = 1'b0;
                if (!xtilde_valid && tq.size() != 0 && (!bp_in || $urandom_range(0, 3) != 0)) begin
                    xtilde_data  = tq.pop_front();
                    xtilde_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        d_flag_valid = 1'b0;
        d_flag_data  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (flush) begin
                d_flag_valid = 1'b0;
                fq.delete();
            end else begin
                if (dflag_fire) d_flag_valid = 1'b0;
                if (!d_flag_valid && fq.size() != 0 && (!bp_in || $urandom_range(0, 3) != 0)) begin
                    d_flag_data  = fq.pop_front();
                    d_flag_valid = 1'b1;
                end
            end
        end
    end

    // Consumers.
    initial begin
        xhatout_ready     = 1'b0;
        xhatoutmean_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            xhatout_ready     = out_hold ? 1'b0 : (bp_out ? ($urandom_range(0, 2) != 0) : 1'b1);
            xhatoutmean_ready = hold_mean ? 1'b0 : (bp_out ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
    end

    // Monitor: everything sampled mid-cycle reflects what the next edge sees.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                xhat_fire   = 1'b0;
                xtilde_fire = 1'b0;
                dflag_fire  = 1'b0;
                nsamp       = 0;
            end else begin
                xhat_fire   = xhat_valid && xhat_ready;
                xtilde_fire = xtilde_valid && xtilde_ready;
                dflag_fire  = d_flag_valid && d_flag_ready;
                if (xhatout_valid && xhatout_ready) begin
                    if (exp_out.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL xhatout_extra: got 0x%0h, expected no beat", xhatout_data);
                    end else begin
                        check("xhatout", 32'(xhatout_data), 32'(exp_out.pop_front()));
                    end
                end
                if (xhatoutmean_valid && xhatoutmean_ready) begin
                    if (exp_mean.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mean_extra: got 0x%0h, expected no beat", xhatoutmean_data);
                    end else begin
                        check("xhatoutmean", 32'(xhatoutmean_data), 32'(exp_mean.pop_front()));
                    end
                end
                if (xhat_fire || xtilde_fire) check("xhat_xtilde_join", 32'(xtilde_fire), 32'(xhat_fire));
                if (dflag_fire) begin
                    check("dflag_on_last", {30'd0, xhat_fire, (nsamp % 256) == 255}, 32'd3);
                    dflag_cnt++;
                end
                if (xhat_fire) nsamp++;
            end
        end
    end

    initial begin
        int fc;
        int n;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_out_valid", 32'(xhatout_valid), 32'd0);
        check("reset_mean_valid", 32'(xhatoutmean_valid), 32'd0);
        check("reset_out_data", 32'(xhatout_data), 32'd0);
        check("reset_mean_data", 32'(xhatoutmean_data), 32'd0);
        check("reset_readies", {29'd0, xhat_ready, xtilde_ready, d_flag_ready}, 32'd0);
        rst = 1'b1;

        // Pass-through: flag 1 selects xhat.
        push_block(1'b1, 0, 16'd100, 16'd5, 256, 100, 1'b1);
        wait_idle("pass_through", 1'b1);

        // Prediction select: flag 0 selects xtilde, flag consumed once.
        fc = dflag_cnt;
        push_block(1'b0, 0, 16'd100, 16'd5, 256, 5, 1'b1);
        wait_idle("predict", 1'b1);
        check("dflag_once", 32'(dflag_cnt - fc), 32'd1);

        // Ramp.
        push_block(1'b1, 1, 16'd0, 16'd5, 256, RampMean, 1'b1);
        wait_idle("ramp", 1'b1);

        // Saturation, two consecutive blocks.
        push_block(1'b1, 0, 16'hffff, 16'd0, 256, 16'hffff, 1'b1);
        push_block(1'b1, 0, 16'hffff, 16'd0, 256, 16'hffff, 1'b1);
        wait_idle("saturation", 1'b1);

        // Random valid/ready toggling, four blocks with alternating flag.
        bp_in  = 1'b1;
        bp_out = 1'b1;
        for (int b = 0; b < 4; b++) begin
            push_block((b % 2) == 0, 2, 16'(b * 1000), 16'(b * 500 + 3), 256, -1, 1'b1);
        end
        wait_idle("backpressure", 1'b1);
        bp_in  = 1'b0;
        bp_out = 1'b0;

        // Mean held: the next block's last sample must stall.
        hold_mean = 1'b1;
        push_block(1'b1, 0, 16'd10, 16'd1, 256, 10, 1'b1);
        push_block(1'b1, 0, 16'd20, 16'd1, 256, 20, 1'b1);
        n = 0;
        while (exp_out.size() != 1 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (20) @(posedge clk);
        #3;
        check("stall_samples_left", 32'(exp_out.size()), 32'd1);
        check("stall_mean_pending", 32'(xhatoutmean_valid), 32'd1);
        check("stall_xhat_ready", 32'(xhat_ready), 32'd0);
        check("stall_dflag_ready", 32'(d_flag_ready), 32'd0);
        hold_mean = 1'b0;
        wait_idle("mean_stall", 1'b1);

        // Reset mid-block: 100 samples, then one more held in the output.
        push_block(1'b1, 0, 16'd1000, 16'd7, 100, -1, 1'b1);
        wait_idle("partial", 1'b0);
        out_hold = 1'b1;
        push_block(1'b1, 0, 16'd1000, 16'd7, 1, -1, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        check("pending_before_reset", 32'(xhatout_valid), 32'd1);
        flush = 1'b1;
        rst   = 1'b0;
        #1;
        check("midreset_out_valid", 32'(xhatout_valid), 32'd0);
        check("midreset_out_data", 32'(xhatout_data), 32'd0);
        check("midreset_mean_valid", 32'(xhatoutmean_valid), 32'd0);
        check("midreset_readies", {29'd0, xhat_ready, xtilde_ready, d_flag_ready}, 32'd0);
        @(posedge clk);
        #3;
        exp_out.delete();
        exp_mean.delete();
        repeat (2) @(posedge clk);
        #3;
        flush    = 1'b0;
        out_hold = 1'b0;
        rst      = 1'b1;
        push_block(1'b1, 0, 16'd300, 16'd7, 256, 300, 1'b1);
        wait_idle("after_reset", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_xhat_precalc.md
Name: next_xhat_precalc

Overview:
- Final-reconstruction stage of the LCPLC block compressor.
- Per sample, selects the raw reconstruction (xhat) or the prediction (xtilde), depending on the block's distortion flag.
- Emits one selected sample per input sample, plus one block mean of the selected samples per block of 2^BLOCK_SIZE_LOG samples.
- Feeds the next-band predictor.

Parameters:
DATA_WIDTH, 16, width of sample data (unsigned).
BLOCK_SIZE_LOG, 8, log2 of samples per block (default block = 256 samples).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, asynchronous, active-low.
xhat_data  in  DATA_WIDTH  raw reconstructed sample.
xhat_valid  in  1  AXIS valid.
xhat_ready  out  1  AXIS ready.
xtilde_data  in  DATA_WIDTH  predicted sample.
xtilde_valid  in  1  AXIS valid.
xtilde_ready  out  1  AXIS ready.
d_flag_data  in  1  block distortion flag; 1 = use xhat, 0 = use xtilde.
d_flag_valid  in  1  AXIS valid.
d_flag_ready  out  1  AXIS ready.
xhatout_data  out  DATA_WIDTH  selected sample.
xhatout_valid  out  1  AXIS valid.
xhatout_ready  in  1  AXIS ready.
xhatoutmean_data  out  DATA_WIDTH  block mean of selected samples.
xhatoutmean_valid  out  1  AXIS valid.
xhatoutmean_ready  in  1  AXIS ready.

Behaviour:
- AXIS semantics: a transfer occurs when valid and ready are both high on a rising edge. Data must stay stable while valid is high and ready is low.
- Reset (rst low, asynchronous):
  - sample counter = 0, accumulator = 0;
  - both output registers empty: xhatout_valid = 0, xhatoutmean_valid = 0, data outputs = 0;
  - all input ready signals = 0.
- Synchronous join: a sample is accepted when all of the following hold:
  - xhat_valid, xtilde_valid and d_flag_valid are all 1;
  - the xhatout register is empty or being drained this cycle (xhatout_ready = 1);
  - if the counter equals 2^BLOCK_SIZE_LOG-1, the mean register is also empty or being drained.
- On acceptance, xhat_ready and xtilde_ready pulse together.
- d_flag_ready is asserted only when the last sample of the block is accepted. The same flag therefore applies to all samples of the block and is consumed once per block.
- Ready signals are combinational from the valids and the output-register state. No input ready depends on its own valid.
- Selected sample = d_flag_data ? xhat_data : xtilde_data.
- Selected sample is registered into xhatout; latency 1 cycle from acceptance to xhatout_valid.
- Throughput: 1 sample/cycle with no backpressure.
- Accumulator:
  - unsigned, DATA_WIDTH+BLOCK_SIZE_LOG bits, no overflow possible;
  - adds each selected sample;
  - the counter increments per accepted sample and wraps to 0 after the last sample.
- On the last sample:
  - mean register <= (accumulator + selected sample) >> BLOCK_SIZE_LOG (floor division);
  - accumulator <= 0;
  - xhatoutmean_valid rises the next cycle, coincident with the block's last xhatout sample.
- A pending mean does not block samples of the following block except that block's last sample. This gives a full block of slack for the mean consumer.
- The xhatout register and the mean register drain independently.
- Reset mid-block discards the partial sum and any pending outputs. The next accepted sample is sample 0 of a new block.

Optional Feature:
- Macro XHAT_MEAN_ROUND_EN.
- When defined: mean = (sum + 2^(BLOCK_SIZE_LOG-1)) >> BLOCK_SIZE_LOG (round half up). The accumulator is widened by 1 bit as required so the add cannot overflow.
- When undefined: floor division as above.
- No interface change either way.

Test Plan:
- Pass-through: 256 samples, xhat = 100, xtilde = 5, d_flag = 1 -> 256 xhatout of 100, one mean = 100.
- Prediction select: same stimulus with d_flag = 0 -> 256 xhatout of 5, mean = 5; d_flag consumed exactly once, on sample 255.
- Ramp: xhat = 0..255, d_flag = 1 -> xhatout = 0..255 in order; mean = 127 (128 with XHAT_MEAN_ROUND_EN).
- Saturation: all xhat = 0xFFFF, d_flag = 1, two consecutive blocks -> both means 0xFFFF, no wrap; counter restarts, second block correct.
- Backpressure:
  - random valid/ready toggling on all five streams, 4 blocks with alternating d_flag -> outputs match the golden sequence, no loss or duplication;
  - xhatoutmean_ready held low -> the last sample of the next block stalls until the mean is taken.
- Reset mid-block: assert rst after 100 samples -> all valids drop at once; next 256-sample block gives a mean computed from the new samples only.
